// File: rtl/bus_arb_pkg.sv
// Shared types for the bidirectional bus arbiter: FSM state encoding and ID width helper.
// Pure declarations; no latency and no backpressure.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  function automatic int ID_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bidir_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping around.
// Latency: combinational. Backpressure: none.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = ID_W(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_rr_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  always_comb begin
    logic [IW-1:0] w_cand;
    o_onehot = '0;
    o_idx    = '0;
    o_vld    = 1'b0;
    w_cand   = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = IW'((int'(i_rr_ptr) + i) % N);
      if (!o_vld && i_req[w_cand]) begin
        o_vld            = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/bidir_bus_arbiter.sv
// Round-robin owner arbiter for the shared A/C tran net, with a dead turnaround gap between owners.
// Latency: grant one edge after a request is seen in IDLE; backpressure: none, requests are held levels.
module bidir_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int TURN_CYC = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          drv_en,
  output logic [ID_W(NUM_REQ)-1:0]    owner_id,
  output logic                        busy,
  output logic                        turn,
  output logic                        preempt
);

  localparam int IW = ID_W(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  arb_state_e         r_state,    w_state_nxt;
  logic [NUM_REQ-1:0] r_grant,    w_grant_nxt;
  logic [IW-1:0]      r_owner,    w_owner_nxt;
  logic [IW-1:0]      r_rr_ptr,   w_rr_ptr_nxt;
  logic [HW-1:0]      r_hold,     w_hold_nxt;
  logic [TW-1:0]      r_turn_cnt, w_turn_cnt_nxt;
  logic               r_preempt,  w_preempt_nxt;

  logic [NUM_REQ-1:0] w_win_oh;
  logic [IW-1:0]      w_win_idx;
  logic               w_win_vld;
  logic               w_own_req;
  logic               w_others;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_vld    (w_win_vld)
  );

  assign w_own_req = req[r_owner];
  assign w_others  = |(req & ~r_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_hold     <= '0;
      r_turn_cnt <= '0;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_hold     <= w_hold_nxt;
      r_turn_cnt <= w_turn_cnt_nxt;
      r_preempt  <= w_preempt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_hold_nxt     = r_hold;
    w_turn_cnt_nxt = r_turn_cnt;
    w_preempt_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_state_nxt  = OWN;
          w_grant_nxt  = w_win_oh;
          w_owner_nxt  = w_win_idx;
          w_rr_ptr_nxt = (w_win_idx == IW'(NUM_REQ - 1)) ? '0 : w_win_idx + IW'(1);
          w_hold_nxt   = '0;
        end
      end
      OWN: begin
        // A release on the same edge as a timeout wins, so no preempt pulse.
        if (!w_own_req || (r_hold == HW'(MAX_HOLD) && w_others)) begin
          w_state_nxt    = TURN;
          w_grant_nxt    = '0;
          w_owner_nxt    = '0;
          w_turn_cnt_nxt = TW'(TURN_CYC);
          w_preempt_nxt  = w_own_req;
        end else if (r_hold != HW'(MAX_HOLD)) begin
          w_hold_nxt = r_hold + HW'(1);
        end
      end
      TURN: begin
        if (r_turn_cnt <= TW'(1)) begin
          w_state_nxt    = IDLE;
          w_turn_cnt_nxt = '0;
        end else begin
          w_turn_cnt_nxt = r_turn_cnt - TW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_owner_nxt = '0;
      end
    endcase
  end

  assign grant    = r_grant;
  assign drv_en   = r_grant;
  assign owner_id = r_owner;
  assign busy     = (r_state != IDLE);
  assign turn     = (r_state == TURN);
  assign preempt  = r_preempt;

endmodule
